vend_coin_arbiter: RTL and testbench

//  Shares one vending_machine core between two coin slots (A, B).

---
 rtl/vend_coin_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_vend_coin_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vend_coin_arbiter.sv
// Two-slot coin arbiter in front of one vending core.
// Per-slot coin FIFOs, round-robin grant, timeout abort with refund.
module vend_coin_arbiter #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 16,
  parameter int PRICE_UNITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin_a,
  input  logic [1:0] coin_b,
  output logic       reject_a,
  output logic       reject_b,
  output logic [1:0] core_in,
  output logic       core_rst,
  input  logic       core_out,
  input  logic [1:0] core_change,
  output logic       vend_a,
  output logic       vend_b,
  output logic [1:0] change_a,
  output logic [1:0] change_b,
  output logic [2:0] refund_a,
  output logic       refund_vld_a,
  output logic [2:0] refund_b,
  output logic       refund_vld_b,
  output logic       busy,
  output logic       owner
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [2:0] PRICE = 3'(PRICE_UNITS);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t state, nxt;

  logic [1:0]    mem [2][FIFO_DEPTH];
  logic [AW:0]   wp [2];
  logic [AW:0]   rp [2];
  logic [1:0]    coin [2];
  logic [1:0]    head [2];
  logic [1:0]    empty, full;
  logic [1:0]    push, pop, rej;

  logic          rr;
  logic [2:0]    credit;
  logic [TW-1:0] timer;
  logic          grant, gsel;
  logic          feed_pop, vend_now, abort_now;
  logic [3:0]    sum;

  assign coin[0] = coin_a;
  assign coin[1] = coin_b;

  // FIFO status and push/pop/reject decisions per slot
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      empty[s] = (wp[s] == rp[s]);
      full[s]  = (wp[s][AW] != rp[s][AW]) &&
                 (wp[s][AW-1:0] == rp[s][AW-1:0]);
      head[s]  = mem[s][rp[s][AW-1:0]];
      pop[s]   = feed_pop && (owner == s[0]);
      push[s]  = (coin[s] == 2'b01 || coin[s] == 2'b10) &&
                 (!full[s] || pop[s]);
      rej[s]   = (coin[s] == 2'b11) ||
                 ((coin[s] != 2'b00) && full[s] && !pop[s]);
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        wp[s] <= '0;
        rp[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          mem[s][wp[s][AW-1:0]] <= coin[s];
          wp[s] <= wp[s] + 1'b1;
        end
        if (pop[s]) rp[s] <= rp[s] + 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // FSM next state and per-cycle control decisions
  always_comb begin
    nxt       = state;
    grant     = 1'b0;
    gsel      = rr;
    feed_pop  = 1'b0;
    vend_now  = 1'b0;
    abort_now = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty[0] || !empty[1]) begin
          grant = 1'b1;
          if (empty[0])      gsel = 1'b1;
          else if (empty[1]) gsel = 1'b0;
          nxt = FEED;
        end
      end
      FEED: begin
        if (core_out) begin
          vend_now = 1'b1;
          nxt      = IDLE;
        end else begin
          feed_pop = !empty[owner] && (credit < PRICE);
          if (!feed_pop && timer == TLAST) begin
            abort_now = 1'b1;
            nxt       = ABORT;
          end
        end
      end
      ABORT:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // saturating credit update for the coin being popped
  always_comb begin
    sum = {1'b0, credit} + {2'b00, head[owner]};
  end

  // transaction bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr       <= 1'b0;
      owner    <= 1'b0;
      credit   <= '0;
      timer    <= '0;
      core_in  <= 2'b00;
      vend_a   <= 1'b0;
      vend_b   <= 1'b0;
      change_a <= 2'b00;
      change_b <= 2'b00;
      reject_a <= 1'b0;
      reject_b <= 1'b0;
    end else begin
      core_in  <= feed_pop ? head[owner] : 2'b00;
      vend_a   <= vend_now && !owner;
      vend_b   <= vend_now && owner;
      change_a <= (vend_now && !owner) ? core_change : 2'b00;
      change_b <= (vend_now && owner) ? core_change : 2'b00;
      reject_a <= rej[0];
      reject_b <= rej[1];
      if (grant) begin
        owner  <= gsel;
        credit <= '0;
        timer  <= '0;
      end else if (state == FEED) begin
        if (vend_now) begin
          credit <= '0;
          timer  <= '0;
          rr     <= ~owner;
        end else if (feed_pop) begin
          credit <= sum[3] ? 3'd7 : sum[2:0];
          timer  <= '0;
        end else if (!abort_now) begin
          timer <= timer + 1'b1;
        end
      end else if (state == ABORT) begin
        credit <= '0;
        timer  <= '0;
        rr     <= ~owner;
      end
    end
  end

  assign busy         = (state != IDLE);
  assign core_rst     = (state == ABORT);
  assign refund_vld_a = core_rst && !owner;
  assign refund_vld_b = core_rst && owner;
  assign refund_a     = refund_vld_a ? credit : 3'd0;
  assign refund_b     = refund_vld_b ? credit : 3'd0;

endmodule

// File: tb/tb_vend_coin_arbiter.sv
// Directed bench for vend_coin_arbiter.
// core_in traffic is checked against a queue of expected {owner, coin}.
module tb_vend_coin_arbiter;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] coin_a = 2'b00;
  logic [1:0] coin_b = 2'b00;
  logic       core_out = 1'b0;
  logic [1:0] core_change = 2'b00;
  logic       reject_a, reject_b;
  logic [1:0] core_in;
  logic       core_rst;
  logic       vend_a, vend_b;
  logic [1:0] change_a, change_b;
  logic [2:0] refund_a, refund_b;
  logic       refund_vld_a, refund_vld_b;
  logic       busy, owner;

  int checks = 0;
  int failures = 0;
  logic [2:0] sb [$];

  vend_coin_arbiter #(
    .FIFO_DEPTH(4), .TIMEOUT(TIMEOUT), .PRICE_UNITS(3)
  ) dut (
    .clk(clk), .rst(rst),
    .coin_a(coin_a), .coin_b(coin_b),
    .reject_a(reject_a), .reject_b(reject_b),
    .core_in(core_in), .core_rst(core_rst),
    .core_out(core_out), .core_change(core_change),
    .vend_a(vend_a), .vend_b(vend_b),
    .change_a(change_a), .change_b(change_b),
    .refund_a(refund_a), .refund_vld_a(refund_vld_a),
    .refund_b(refund_b), .refund_vld_b(refund_vld_b),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic logic [20:0] all_out();
    return {reject_a, reject_b, core_in, core_rst, vend_a,
            vend_b, change_a, change_b, refund_a, refund_vld_a,
            refund_b, refund_vld_b, busy, owner};
  endfunction

  // scoreboard: every forwarded coin must be the next expected one
  always @(negedge clk) begin
    if (rst && core_in != 2'b00) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", {29'd0, owner, core_in}, 32'd0);
      end else begin
        chk("sb_core_in", {29'd0, owner, core_in},
            {29'd0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] a, input logic [1:0] b);
    coin_a = a;
    coin_b = b;
    tick();
    coin_a = 2'b00;
    coin_b = 2'b00;
  endtask

  task automatic vend(input logic [1:0] chg);
    core_out    = 1'b1;
    core_change = chg;
    tick();
    core_out    = 1'b0;
    core_change = 2'b00;
  endtask

  task automatic wait_sb(input string tag, input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    tick();
    chk(tag, sb.size(), 0);
  endtask

  task automatic wait_rst(input int maxc, output int n);
    n = 0;
    while (!core_rst && n < maxc) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic pulses;

    repeat (3) tick();
    chk("reset_outputs", {11'd0, all_out()}, 32'd0);
    rst = 1'b1;
    tick();

    // A and B together with rr at A: A first, then B
    sb.push_back({1'b0, 2'b10});
    drive(2'b10, 2'b10);
    wait_sb("t2_a_fwd", 8);
    chk("t2_owner_a", {31'd0, owner}, 32'd0);
    tick();
    tick();
    vend(2'b01);
    chk("t2_vend_a", {30'd0, vend_a, vend_b}, 32'd2);
    chk("t2_change_a", {28'd0, change_a, change_b}, 32'h4);
    sb.push_back({1'b1, 2'b10});
    wait_sb("t2_b_fwd", 8);
    chk("t2_owner_b", {30'd0, busy, owner}, 32'd3);
    vend(2'b10);
    chk("t2_vend_b", {30'd0, vend_a, vend_b}, 32'd1);
    chk("t2_change_b", {28'd0, change_a, change_b}, 32'h2);
    tick();

    // A: 10 then 5 back-to-back, then vend
    sb.push_back({1'b0, 2'b10});
    sb.push_back({1'b0, 2'b01});
    drive(2'b10, 2'b00);
    drive(2'b01, 2'b00);
    wait_sb("t1_fwd", 8);
    chk("t1_busy", {30'd0, busy, owner}, 32'd2);
    vend(2'b00);
    chk("t1_vend", {29'd0, vend_a, vend_b, busy}, 32'd4);
    chk("t1_change", {28'd0, change_a, change_b}, 32'd0);
    tick();
    chk("t1_pulse_end", {31'd0, vend_a}, 32'd0);

    // A: single 5 then nothing -> timeout abort
    sb.push_back({1'b0, 2'b01});
    drive(2'b01, 2'b00);
    wait_rst(40, n);
    chk("t3_abort_cycle", n + 1, TIMEOUT + 3);
    chk("t3_refund_a",
        {24'd0, core_rst, refund_vld_a, refund_a, refund_vld_b},
        {24'd0, 1'b1, 1'b1, 3'd1, 1'b0});
    tick();
    chk("t3_after", {29'd0, core_rst, refund_vld_a, busy}, 32'd0);

    // B owns; A fills its FIFO, fifth and invalid coins refused
    sb.push_back({1'b1, 2'b01});
    drive(2'b00, 2'b01);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(2'b10, 2'b00);
      chk($sformatf("t4_rej_%0d", i), {31'd0, reject_a},
          (i == 4) ? 32'd1 : 32'd0);
    end
    drive(2'b11, 2'b00);
    chk("t4_rej_inv", {30'd0, reject_a, reject_b}, 32'd2);
    tick();
    chk("t4_rej_clr", {31'd0, reject_a}, 32'd0);
    sb.push_back({1'b0, 2'b10});
    sb.push_back({1'b0, 2'b10});
    wait_rst(40, n);
    chk("t4_refund_b",
        {26'd0, core_rst, refund_vld_b, refund_b, refund_vld_a},
        {26'd0, 1'b1, 1'b1, 3'd1, 1'b0});
    wait_sb("t4_a_fwd", 8);
    tick();
    tick();
    vend(2'b00);
    chk("t4_vend_a", {31'd0, vend_a}, 32'd1);

    // remaining two queued tens form the next A transaction
    sb.push_back({1'b0, 2'b10});
    sb.push_back({1'b0, 2'b10});
    wait_sb("t4_rest_fwd", 8);
    vend(2'b00);
    tick();

    // A: 10,10,5 -> the 5 waits for the following A transaction
    sb.push_back({1'b0, 2'b10});
    sb.push_back({1'b0, 2'b10});
    drive(2'b10, 2'b00);
    drive(2'b10, 2'b00);
    drive(2'b01, 2'b00);
    wait_sb("t5_fwd", 8);
    tick();
    tick();
    vend(2'b01);
    chk("t5_vend", {28'd0, vend_a, vend_b, change_a}, 32'h9);
    sb.push_back({1'b0, 2'b01});
    wait_sb("t5_held_fwd", 8);
    chk("t5_owner", {30'd0, busy, owner}, 32'd2);

    // reset in FEED with a B coin queued
    drive(2'b00, 2'b10);
    rst = 1'b0;
    tick();
    chk("t6_reset_outputs", {11'd0, all_out()}, 32'd0);
    rst = 1'b1;
    pulses = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses |= vend_a | vend_b | refund_vld_a |
                refund_vld_b | busy | core_rst;
    end
    chk("t6_quiet", {31'd0, pulses}, 32'd0);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
